fifo_vc_umbral: RTL

// - Virtual-channel data FIFO that sits directly upstream of fsmControl.
// - Buffers DATA_W-bit words and produces fifo_empty and fifo_error, which fsmControl consumes.
// - Takes fsmControl's umbrales_VCFC and turns it into programmable almost-full and

---
 rtl/fifo_vc_umbral_pkg.sv | 35 +++
 rtl/fifo_mem_dp.sv | 36 +++
 rtl/fifo_vc_umbral.sv | 115 +++++++++++
 3 files changed

// File: rtl/fifo_vc_umbral_pkg.sv
// Shared definitions for the virtual-channel FIFO and fsmControl: default sizing,
// umbrales_VCFC field positions and threshold decode helpers.
package fifo_vc_umbral_pkg;

  localparam int VC_DATA_W = 6;
  localparam int VC_DEPTH  = 8;
  localparam int VC_PTR_W  = 3;

  localparam int AF_MSB = 7;
  localparam int AF_LSB = 4;
  localparam int AE_MSB = 3;
  localparam int AE_LSB = 0;

  // A zero or out-of-range almost-full threshold means "only when completely full".
  function automatic logic [3:0] af_eff(input logic [3:0] af, input logic [3:0] depth);
    logic [3:0] res;
    if ((af == 4'd0) || (af > depth)) begin
      res = depth;
    end else begin
      res = af;
    end
    return res;
  endfunction

  function automatic logic [3:0] ae_eff(input logic [3:0] ae, input logic [3:0] depth);
    logic [3:0] res;
    if (ae > depth) begin
      res = depth;
    end else begin
      res = ae;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Register-array storage for the VC FIFO: one write port, one registered read port.
// Array contents are deliberately not reset; only the read register is.
module fifo_mem_dp #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write; a same-cycle read of this slot still sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port holds its last word between pops.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_data <= DATA_W'(0);
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_vc_umbral.sv
// Virtual-channel data FIFO feeding fsmControl, with programmable almost-full /
// almost-empty flags derived from umbrales_VCFC and a sticky over/underflow flag.
module fifo_vc_umbral
  import fifo_vc_umbral_pkg::*;
#(
  parameter int DATA_W = VC_DATA_W,
  parameter int DEPTH  = VC_DEPTH,
  parameter int PTR_W  = VC_PTR_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [7:0]        umbrales_VCFC,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              fifo_error,
  output logic [PTR_W:0]    fifo_count
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             valid_r;
  logic             error_r;
  logic [7:0]       thr_r;

  logic             empty_s;
  logic             full_s;
  logic             pop_ok_s;
  logic             push_ok_s;
  logic             bad_op_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [3:0]       af_lvl_s;
  logic [3:0]       ae_lvl_s;

  // Accept decisions from the current registered occupancy.
  always_comb begin
    empty_s   = (count_r == CNT_W'(0));
    full_s    = (count_r == CNT_W'(DEPTH));
    pop_ok_s  = pop & ~empty_s;
    push_ok_s = push & (~full_s | pop_ok_s);
    bad_op_s  = (push & ~push_ok_s) | (pop & empty_s);
  end

  // Occupancy next-state.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count, pop strobe, sticky error and threshold capture.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
      thr_r    <= 8'h00;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      valid_r <= pop_ok_s;
      error_r <= error_r | bad_op_s;
      thr_r   <= umbrales_VCFC;
    end
  end

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .reset_L (reset_L),
    .wr_en   (push_ok_s),
    .wr_addr (wr_ptr_r),
    .wr_data (data_in),
    .rd_en   (pop_ok_s),
    .rd_addr (rd_ptr_r),
    .rd_data (data_out)
  );

  // Flags decode only registered state, so push/pop cannot glitch them.
  always_comb begin
    af_lvl_s     = af_eff(thr_r[AF_MSB:AF_LSB], 4'(DEPTH));
    ae_lvl_s     = ae_eff(thr_r[AE_MSB:AE_LSB], 4'(DEPTH));
    fifo_empty   = empty_s;
    fifo_full    = full_s;
    almost_full  = (5'(count_r) >= {1'b0, af_lvl_s});
    almost_empty = (5'(count_r) <= {1'b0, ae_lvl_s});
  end

  assign valid_out  = valid_r;
  assign fifo_error = error_r;
  assign fifo_count = count_r;

endmodule
